// File: rtl/ahb_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ahb_master_if : AHB-Lite style bus bundle between ahb_master and a slave   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

interface ahb_master_if #(
  parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AHB_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] haddr_m2s;
  logic                  hwrite;
  logic                  hsel;
  logic [DATA_WIDTH-1:0] hdata_m2s;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output haddr_m2s, hwrite, hsel, hdata_m2s,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr_m2s, hwrite, hsel, hdata_m2s,
    output hready, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/ahb_master.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ahb_master : single-outstanding AHB-Lite style initiator with timeout      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master #(
  parameter int ADDR_WIDTH     = `AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `AHB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  ahb_master_if.master          bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int                 c_cnt_w      = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(TIMEOUT_CYCLES);
  localparam bit                 c_timeout_en = (TIMEOUT_CYCLES != 0);

  state_t                r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [c_cnt_w-1:0]    r_wait;
  logic                  r_req_ready;
  logic                  r_hsel;
  logic [DATA_WIDTH-1:0] r_hdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [c_cnt_w-1:0]    w_wait_next;
  logic                  w_wait_sat;
  logic                  w_err_now;
  logic                  w_timeout;

  assign w_wait_next = r_wait + 1'b1;
  assign w_wait_sat  = (r_wait == {c_cnt_w{1'b1}});
  // Error seen this cycle counts even when it arrives together with hready.
  assign w_err_now   = r_err | bus.hresp;
  assign w_timeout   = c_timeout_en && !bus.hready && (w_wait_next == c_timeout);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_wait      <= '0;
      r_req_ready <= 1'b1;
      r_hsel      <= 1'b0;
      r_hdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_hsel      <= 1'b1;
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.hready) begin
            r_hsel  <= 1'b0;
            r_wait  <= '0;
            r_hdata <= r_write ? r_wdata : '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.hresp) begin
            r_err <= 1'b1;
          end
          if (bus.hready) begin
            r_rsp_err   <= w_err_now;
            r_rsp_rdata <= (!r_write && !w_err_now) ? bus.hrdata : '0;
            r_rsp_valid <= 1'b1;
            r_hdata     <= '0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_hdata     <= '0;
            r_state     <= ST_RESP;
          end else if (!w_wait_sat) begin
            r_wait <= w_wait_next;
          end
        end
        ST_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_hsel      <= 1'b0;
          r_hdata     <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign bus.haddr_m2s = r_addr;
  assign bus.hwrite    = r_write;
  assign bus.hsel      = r_hsel;
  assign bus.hdata_m2s = r_hdata;

endmodule

`default_nettype wire
